matmul_core: RTL and testbench
==============================

MATMUL_CORE -- requirements
Module: matmul_core

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, matrix element, accumulator and memory data width.
REQ-002 SHALL provide parameter ADDR_W, default 8, data-memory address width.
REQ-003 SHALL provide parameter DIM_W, default 4, width of each matrix dimension input.
REQ-004 SHALL provide parameter CORE_ID, default 0, index of this core within the multicore array.
REQ-005 SHALL provide parameter NUM_CORES, default 1, number of cores sharing the row space; CORE_ID < NUM_CORES.
REQ-006 SHALL provide port `clock`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL provide port `rst`, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL provide port `start`, input, 1 bit: request to begin a multiply; sampled only in IDLE.
REQ-009 SHALL provide ports `dim_i`, `dim_j`, `dim_k`, input, DIM_W bits each: dimensions of D[I][J] = A[I][K] x B[K][J].
REQ-010 SHALL provide ports `base_a`, `base_b`, `base_d`, input, ADDR_W bits each: row-major base addresses of A, B and D.
REQ-011 SHALL provide port `busy`, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL provide port `done`, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL provide port `mem_we`, output, 1 bit: data-memory write enable.
REQ-014 SHALL provide port `mem_addr`, output, ADDR_W bits: data-memory address.
REQ-015 SHALL provide port `mem_wdata`, output, DATA_W bits: data-memory write data.
REQ-016 SHALL provide port `mem_rdata`, input, DATA_W bits: data-memory read data, valid the cycle after its address is presented (synchronous RAM).

Function
REQ-017 SHALL implement FSM states IDLE, RD_A, RD_B, MAC, WRITE, FINISH.
REQ-018 In IDLE with start=1, SHALL latch all dims and bases, set i=CORE_ID, j=0, k=0, acc=0, and go to RD_A.
- If dim_i, dim_j or dim_k is 0, or CORE_ID >= dim_i, SHALL go directly to FINISH instead.
REQ-019 In RD_A, SHALL drive mem_addr = base_a + i*K + k with mem_we=0, then go to RD_B.
REQ-020 In RD_B, SHALL drive mem_addr = base_b + k*J + j, capture mem_rdata as operand a, then go to MAC.
REQ-021 In MAC, SHALL set acc = acc + a*mem_rdata.
- If k < K-1: increment k and go to RD_A.
- Otherwise: go to WRITE.
REQ-022 In WRITE, SHALL drive mem_we=1, mem_addr = base_d + i*J + j and mem_wdata = acc, then clear acc and k.
- If j < J-1: increment j and go to RD_A.
- Otherwise: set j=0 and i = i + NUM_CORES; go to RD_A if the new i < I, else to FINISH.
REQ-023 In FINISH, SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-024 Arithmetic SHALL be unsigned; product and acc truncate modulo 2^DATA_W; addresses wrap modulo 2^ADDR_W.
REQ-025 Per output element, latency SHALL be exactly 3K+1 cycles; no idle cycles between elements.
REQ-026 start while busy=1 SHALL be ignored; latched dims and bases SHALL NOT change mid-run.
REQ-027 mem_we SHALL be 1 only in WRITE; in every other state mem_we=0 and mem_wdata=0; in IDLE and FINISH mem_addr=0.
REQ-028 Index counters SHALL be wide enough for i + NUM_CORES without overflow; the row-termination compare SHALL use that widened value.

Reset
REQ-029 When rst=1 at a rising edge, SHALL go to IDLE with busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, and acc, a, i, j, k all zero.
REQ-030 Reset SHALL override start and any state, including mid-operation; no further write and no done pulse SHALL follow an aborted run.

Verification
REQ-031 I=J=K=2, A={1,2,3,4} at 0x00, B=identity at 0x10, D at 0x20 -> D={1,2,3,4}; 4 writes; done high 29 cycles after the start-sampling edge.
REQ-032 I=2, K=3, J=2, A={1,2,3,4,5,6}, B={7,8,9,10,11,12} -> D={58,64,139,154}; each write exactly 10 cycles apart.
REQ-033 NUM_CORES=2, CORE_ID=1, I=3, J=K=2 -> only row 1 is written (addresses base_d+2, base_d+3); core with CORE_ID=0 writes rows 0 and 2.
REQ-034 dim_k=0 with start=1 -> no memory write; done pulses in the 2nd cycle after start; start asserted during FINISH is ignored.
REQ-035 DATA_W=16, A[0][0]=0x0100, B[0][0]=0x0100, I=J=K=1 -> D[0][0]=0x0000 (wrap); rst asserted during a RD_B cycle -> next cycle IDLE, mem_we never rises, done never pulses.

Source files
------------

// File: rtl/matmul_core.sv
// matmul_core: sequential integer matrix multiplier, D = A x B, with one
// multiply-accumulate per three cycles against a synchronous single-port RAM.
// Several cores can share the row space: this core handles rows CORE_ID,
// CORE_ID+NUM_CORES, ...
`timescale 1ns/1ps
module matmul_core #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int DIM_W     = 4,
    parameter int CORE_ID   = 0,
    parameter int NUM_CORES = 1
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  dim_i,
    input  logic [DIM_W-1:0]  dim_j,
    input  logic [DIM_W-1:0]  dim_k,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_d,
    output logic              busy,
    output logic              done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    // Row index must hold i + NUM_CORES without wrapping.
    localparam int IDX_W = DIM_W + $clog2(NUM_CORES + 1);
    // Index products are formed at least ADDR_W wide, then wrap to ADDR_W.
    localparam int PW = (IDX_W + DIM_W > ADDR_W) ? IDX_W + DIM_W : ADDR_W;

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, WRITE, FINISH} state_t;

    state_t            state_q, state_d;
    logic [DIM_W-1:0]  dim_i_q, dim_i_d, dim_j_q, dim_j_d, dim_k_q, dim_k_d;
    logic [ADDR_W-1:0] base_a_q, base_a_d, base_b_q, base_b_d, base_d_q, base_d_d;
    logic [IDX_W-1:0]  i_q, i_d;
    logic [DIM_W-1:0]  j_q, j_d, k_q, k_d;
    logic [DATA_W-1:0] acc_q, acc_d, a_q, a_d;

    logic [PW-1:0]     prod_ik, prod_kj, prod_ij;
    logic [ADDR_W-1:0] addr_a, addr_b, addr_d;
    logic [IDX_W-1:0]  i_next;

    // Element addresses for the current (i, j, k) position.
    always_comb begin
        prod_ik = PW'(i_q) * PW'(dim_k_q);
        prod_kj = PW'(k_q) * PW'(dim_j_q);
        prod_ij = PW'(i_q) * PW'(dim_j_q);
        addr_a  = base_a_q + prod_ik[ADDR_W-1:0] + ADDR_W'(k_q);
        addr_b  = base_b_q + prod_kj[ADDR_W-1:0] + ADDR_W'(j_q);
        addr_d  = base_d_q + prod_ij[ADDR_W-1:0] + ADDR_W'(j_q);
        i_next  = i_q + IDX_W'(NUM_CORES);
    end

    // Next-state, datapath updates and memory port drive.
    always_comb begin
        state_d   = state_q;
        dim_i_d   = dim_i_q;
        dim_j_d   = dim_j_q;
        dim_k_d   = dim_k_q;
        base_a_d  = base_a_q;
        base_b_d  = base_b_q;
        base_d_d  = base_d_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        acc_d     = acc_q;
        a_d       = a_q;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dim_i_d  = dim_i;
                    dim_j_d  = dim_j;
                    dim_k_d  = dim_k;
                    base_a_d = base_a;
                    base_b_d = base_b;
                    base_d_d = base_d;
                    i_d      = IDX_W'(CORE_ID);
                    j_d      = '0;
                    k_d      = '0;
                    acc_d    = '0;
                    // Empty product or no row for this core: nothing to write.
                    if (dim_i == '0 || dim_j == '0 || dim_k == '0 ||
                        IDX_W'(CORE_ID) >= IDX_W'(dim_i))
                        state_d = FINISH;
                    else
                        state_d = RD_A;
                end
            end
            RD_A: begin
                mem_addr = addr_a;
                state_d  = RD_B;
            end
            RD_B: begin
                mem_addr = addr_b;
                a_d      = mem_rdata;
                state_d  = MAC;
            end
            MAC: begin
                acc_d = acc_q + a_q * mem_rdata;
                if (k_q + DIM_W'(1) != dim_k_q) begin
                    k_d     = k_q + DIM_W'(1);
                    state_d = RD_A;
                end else begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = addr_d;
                mem_wdata = acc_q;
                acc_d     = '0;
                k_d       = '0;
                if (j_q + DIM_W'(1) != dim_j_q) begin
                    j_d     = j_q + DIM_W'(1);
                    state_d = RD_A;
                end else begin
                    j_d     = '0;
                    i_d     = i_next;
                    state_d = (i_next < IDX_W'(dim_i_q)) ? RD_A : FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == FINISH);

    // State and datapath registers; reset clears everything and aborts a run.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q  <= IDLE;
            dim_i_q  <= '0;
            dim_j_q  <= '0;
            dim_k_q  <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            base_d_q <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            a_q      <= '0;
        end else begin
            state_q  <= state_d;
            dim_i_q  <= dim_i_d;
            dim_j_q  <= dim_j_d;
            dim_k_q  <= dim_k_d;
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            base_d_q <= base_d_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
        end
    end

endmodule

// File: tb/tb_matmul_core.sv
// tb_matmul_core: directed vectors against a shared synchronous RAM model.
// Instance 0 is a single core; instances 1 and 2 form a two-core array.
// Expected writes are queued per instance; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_matmul_core;
    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start0 = 1'b0;
    logic             start_m = 1'b0;
    logic [3:0]       dim_i = '0, dim_j = '0, dim_k = '0;
    logic [7:0]       base_a = '0, base_b = '0, base_d = '0;
    logic [2:0]       busy, done, we;
    logic [2:0][7:0]  addr;
    logic [2:0][15:0] wdata, rdata;
    logic [15:0]      mem [256];

    wr_t q0[$], q1[$], q2[$];
    int  n_cmp = 0, n_bad = 0, cyc = 0;
    int  done_cnt[3] = '{0, 0, 0};
    int  done_cyc[3] = '{0, 0, 0};
    int  gap_exp = 0, last_wr = 0, start_cyc = 0;
    bit  have_prev = 0;

    always #5 clk = ~clk;

    matmul_core u_dut (
        .clock(clk), .rst(rst), .start(start0), .dim_i(dim_i), .dim_j(dim_j), .dim_k(dim_k),
        .base_a(base_a), .base_b(base_b), .base_d(base_d), .busy(busy[0]), .done(done[0]),
        .mem_we(we[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]));
    matmul_core #(.CORE_ID(0), .NUM_CORES(2)) u_c0 (
        .clock(clk), .rst(rst), .start(start_m), .dim_i(dim_i), .dim_j(dim_j), .dim_k(dim_k),
        .base_a(base_a), .base_b(base_b), .base_d(base_d), .busy(busy[1]), .done(done[1]),
        .mem_we(we[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]));
    matmul_core #(.CORE_ID(1), .NUM_CORES(2)) u_c1 (
        .clock(clk), .rst(rst), .start(start_m), .dim_i(dim_i), .dim_j(dim_j), .dim_k(dim_k),
        .base_a(base_a), .base_b(base_b), .base_d(base_d), .busy(busy[2]), .done(done[2]),
        .mem_we(we[2]), .mem_addr(addr[2]), .mem_wdata(wdata[2]), .mem_rdata(rdata[2]));

    // Synchronous read RAM, one read port per core; writes are only checked.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) rdata[d] <= mem[addr[d]];
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_wr(input int d, input bit empty, input wr_t e);
        if (empty) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write%0d: addr 0x%0h data 0x%0h expected no write",
                     d, addr[d], wdata[d]);
        end else begin
            chk($sformatf("wr%0d_addr", d), int'(addr[d]), int'(e.addr));
            chk($sformatf("wr%0d_data", d), int'(wdata[d]), int'(e.data));
        end
    endtask

    // Monitor: pops the scoreboard on every write, tracks done pulses.
    always @(negedge clk) begin
        wr_t e;
        for (int d = 0; d < 3; d++) if (done[d]) begin
            done_cnt[d]++;
            done_cyc[d] = cyc;
        end
        if (we[0]) begin
            e = '0;
            if (q0.size() != 0) e = q0[0];
            check_wr(0, q0.size() == 0, e);
            if (q0.size() != 0) void'(q0.pop_front());
            if (gap_exp != 0 && have_prev) chk("wr0_gap", cyc - last_wr, gap_exp);
            have_prev = 1;
            last_wr = cyc;
        end
        if (we[1]) begin
            e = '0;
            if (q1.size() != 0) e = q1[0];
            check_wr(1, q1.size() == 0, e);
            if (q1.size() != 0) void'(q1.pop_front());
        end
        if (we[2]) begin
            e = '0;
            if (q2.size() != 0) e = q2[0];
            check_wr(2, q2.size() == 0, e);
            if (q2.size() != 0) void'(q2.pop_front());
        end
    end

    task automatic set_op(input int i, input int j, input int k,
                          input int ba, input int bb, input int bd);
        dim_i = 4'(i); dim_j = 4'(j); dim_k = 4'(k);
        base_a = 8'(ba); base_b = 8'(bb); base_d = 8'(bd);
    endtask

    task automatic push0(input int a, input int v);
        wr_t e;
        e.addr = 8'(a);
        e.data = 16'(v);
        q0.push_back(e);
    endtask

    // Pulses start on core 0; start_cyc is the cycle count of the sampling edge.
    task automatic go0();
        @(negedge clk);
        start0 = 1'b1;
        have_prev = 0;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start0 = 1'b0;
    endtask

    // Waits for one done pulse on core 0, bounded; a timeout shows as a failed compare.
    task automatic wait_done0(input string name, input int prev, input int budget);
        int n = 0;
        while (done_cnt[0] == prev && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({name, "_done_seen"}, done_cnt[0], prev + 1);
    endtask

    initial begin
        int p, p1, p2, n;
        wr_t e;
        for (int a = 0; a < 256; a++) mem[a] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_done", int'(done[0]), 0);
        chk("rst_we", int'(we[0]), 0);
        chk("rst_addr", int'(addr[0]), 0);
        chk("rst_wdata", int'(wdata[0]), 0);
        rst = 1'b0;

        // 2x2 by identity: D = A, 4 elements of 7 cycles, done closes 29 edges on.
        mem[8'h00] = 1; mem[8'h01] = 2; mem[8'h02] = 3; mem[8'h03] = 4;
        mem[8'h10] = 1; mem[8'h11] = 0; mem[8'h12] = 0; mem[8'h13] = 1;
        set_op(2, 2, 2, 'h00, 'h10, 'h20);
        push0('h20, 1); push0('h21, 2); push0('h22, 3); push0('h23, 4);
        gap_exp = 7;
        p = done_cnt[0];
        go0();
        chk("t1_busy", int'(busy[0]), 1);
        wait_done0("t1", p, 100);
        chk("t1_done_latency", done_cyc[0] - start_cyc + 1, 29);
        chk("t1_pending", q0.size(), 0);

        // 2x3 by 3x2: 58 64 / 139 154, writes 10 cycles apart.
        mem[8'h00] = 1; mem[8'h01] = 2; mem[8'h02] = 3;
        mem[8'h03] = 4; mem[8'h04] = 5; mem[8'h05] = 6;
        mem[8'h10] = 7; mem[8'h11] = 8; mem[8'h12] = 9;
        mem[8'h13] = 10; mem[8'h14] = 11; mem[8'h15] = 12;
        set_op(2, 2, 3, 'h00, 'h10, 'h30);
        push0('h30, 58); push0('h31, 64); push0('h32, 139); push0('h33, 154);
        gap_exp = 10;
        p = done_cnt[0];
        go0();
        wait_done0("t2", p, 100);
        chk("t2_pending", q0.size(), 0);
        gap_exp = 0;

        // K = 0: straight to FINISH; start held high through FINISH is ignored.
        set_op(2, 2, 0, 'h00, 'h10, 'h40);
        p = done_cnt[0];
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        chk("t3_idle_after_finish", int'(busy[0]), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("t3_done_count", done_cnt[0] - p, 1);
        chk("t3_done_latency", done_cyc[0] - start_cyc + 1, 1);

        // Product wraps: 0x100 * 0x100 mod 2^16 = 0.
        mem[8'h40] = 16'h0100; mem[8'h41] = 16'h0100;
        set_op(1, 1, 1, 'h40, 'h41, 'h50);
        push0('h50, 0);
        p = done_cnt[0];
        go0();
        wait_done0("t4", p, 50);
        chk("t4_pending", q0.size(), 0);

        // Reset during RD_B: abort, no write and no done afterwards.
        set_op(2, 2, 2, 'h00, 'h10, 'h60);
        p = done_cnt[0];
        go0();
        @(posedge clk);
        #1;
        chk("t5_rdb_addr", int'(addr[0]), 'h10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_abort_busy", int'(busy[0]), 0);
        chk("t5_abort_addr", int'(addr[0]), 0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("t5_no_done", done_cnt[0], p);

        // Two cores over 3 rows, B = identity: core 1 owns row 1, core 0 rows 0 and 2.
        mem[8'h00] = 1; mem[8'h01] = 2; mem[8'h02] = 3;
        mem[8'h03] = 4; mem[8'h04] = 5; mem[8'h05] = 6;
        mem[8'h10] = 1; mem[8'h11] = 0; mem[8'h12] = 0; mem[8'h13] = 1;
        set_op(3, 2, 2, 'h00, 'h10, 'h70);
        e.addr = 8'h70; e.data = 16'd1; q1.push_back(e);
        e.addr = 8'h71; e.data = 16'd2; q1.push_back(e);
        e.addr = 8'h74; e.data = 16'd5; q1.push_back(e);
        e.addr = 8'h75; e.data = 16'd6; q1.push_back(e);
        e.addr = 8'h72; e.data = 16'd3; q2.push_back(e);
        e.addr = 8'h73; e.data = 16'd4; q2.push_back(e);
        p1 = done_cnt[1];
        p2 = done_cnt[2];
        @(negedge clk);
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        n = 0;
        while ((done_cnt[1] == p1 || done_cnt[2] == p2) && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("mc_core0_done", done_cnt[1], p1 + 1);
        chk("mc_core1_done", done_cnt[2], p2 + 1);
        chk("mc_core0_pending", q1.size(), 0);
        chk("mc_core1_pending", q2.size(), 0);
        chk("main_pending", q0.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
